bt656cap_dma: RTL and testbench

//  Frame-capture DMA for bt656cap. Packs decoded RGB565 pixels into 32-byte bursts
//  and writes them to SDRAM over FML. Sits between the BT.656 decoder and the FML
//  bus, and drives the start_of_frame/next_burst/in_frame handshake into
//  bt656cap_ctlif, from which it takes field_filter, fml_adr_base and last_burst.

---
 rtl/bt656cap_dma_pkg.sv | 27 ++
 rtl/bt656cap_dma_if.sv | 31 +++
 rtl/bt656cap_burstbuf.sv | 79 +++++++
 rtl/bt656cap_dma.sv | 149 ++++++++++++++
 tb/tb_bt656cap_dma.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bt656cap_dma_pkg.sv
// Shared constants, FSM encoding and packing helper for the bt656cap frame-capture DMA.
package bt656cap_dma_pkg;

    localparam int unsigned PixPerBurst   = 16;
    localparam int unsigned WordsPerBurst = 4;
    localparam int unsigned BurstBytes    = 32;

    localparam int unsigned BurstAdrBits = $clog2(BurstBytes);
    localparam int unsigned PixIdxBits   = $clog2(PixPerBurst);
    localparam int unsigned WordIdxBits  = $clog2(WordsPerBurst);

    // Write-side FSM: request, three trailing data beats, then a check cycle for last_burst.
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StD1,
        StD2,
        StD3,
        StChk
    } wr_state_e;

    // LSB of a pixel slot inside a 64-bit word; slot 0 lands in the top halfword.
    function automatic int unsigned px_lsb(input logic [1:0] slot);
        return 32'd48 - 32'(slot) * 32'd16;
    endfunction

endpackage

// File: rtl/bt656cap_dma_if.sv
// FML write-port bundle between the capture DMA (master) and the memory controller (slave).
interface bt656cap_dma_if #(
    parameter int unsigned fml_depth = 27
);

    logic [fml_depth-1:0] fml_adr;
    logic                 fml_stb;
    logic                 fml_we;
    logic [7:0]           fml_sel;
    logic [63:0]          fml_do;
    logic                 fml_ack;

    modport master (
        output fml_adr,
        output fml_stb,
        output fml_we,
        output fml_sel,
        output fml_do,
        input  fml_ack
    );

    modport slave (
        input  fml_adr,
        input  fml_stb,
        input  fml_we,
        input  fml_sel,
        input  fml_do,
        output fml_ack
    );

endinterface

// File: rtl/bt656cap_burstbuf.sv
// Two 4x64b ping-pong burst buffers: RGB565 packer on the write side, word reader on the read side.
// Buffers fill and drain in the same alternating order, so the read pointer always names
// the oldest full buffer.
module bt656cap_burstbuf
    import bt656cap_dma_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [15:0]            wr_data_i,
    input  logic                   free_i,
    input  logic [WordIdxBits-1:0] rd_word_i,
    output logic                   wr_full_o,
    output logic                   rd_ready_o,
    output logic [63:0]            rd_data_o
);

    logic [1:0]            full_q, full_d;
    logic                  wr_buf_q, wr_buf_d;
    logic                  rd_buf_q, rd_buf_d;
    logic [PixIdxBits-1:0] wr_idx_q, wr_idx_d;
    logic [63:0]           mem_q [2][WordsPerBurst];

    // Status and read data; a buffer being freed this cycle already counts as empty.
    always_comb begin
        wr_full_o  = full_q[wr_buf_q] & ~(free_i & (rd_buf_q == wr_buf_q));
        rd_ready_o = full_q[rd_buf_q];
        rd_data_o  = mem_q[rd_buf_q][rd_word_i];
    end

    // Flag and pointer next-state; flush wins over everything.
    always_comb begin
        full_d   = full_q;
        wr_buf_d = wr_buf_q;
        rd_buf_d = rd_buf_q;
        wr_idx_d = wr_idx_q;
        if (free_i) begin
            full_d[rd_buf_q] = 1'b0;
            rd_buf_d         = ~rd_buf_q;
        end
        if (wr_en_i) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_idx_q == PixIdxBits'(PixPerBurst - 1)) begin
                full_d[wr_buf_q] = 1'b1;
                wr_buf_d         = ~wr_buf_q;
            end
        end
        if (flush_i) begin
            full_d   = '0;
            wr_buf_d = 1'b0;
            rd_buf_d = 1'b0;
            wr_idx_d = '0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q   <= '0;
            wr_buf_q <= 1'b0;
            rd_buf_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            full_q   <= full_d;
            wr_buf_q <= wr_buf_d;
            rd_buf_q <= rd_buf_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    // Pixel storage, big-endian within each word; data needs no reset since flags gate it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_buf_q][wr_idx_q[3:2]][px_lsb(wr_idx_q[1:0]) +: 16] <= wr_data_i;
        end
    end

endmodule

// File: rtl/bt656cap_dma.sv
// Frame-capture DMA: starts on a filtered SOF, packs pixels into 32-byte bursts and writes
// them to SDRAM over FML, handshaking burst progress with the control interface.
module bt656cap_dma
    import bt656cap_dma_pkg::*;
#(
    parameter int unsigned fml_depth = 27
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  v_stb,
    input  logic                  v_sof,
    input  logic                  v_field,
    input  logic [15:0]           v_rgb565,
    input  logic [1:0]            field_filter,
    input  logic [fml_depth-6:0]  fml_adr_base,
    input  logic                  last_burst,
    output logic                  in_frame,
    output logic                  start_of_frame,
    output logic                  next_burst,
    output logic                  overflow,
    bt656cap_dma_if.master        fml
);

    localparam int unsigned PtrW = fml_depth - BurstAdrBits;

    wr_state_e             state_q, state_d;
    logic                  in_frame_q, in_frame_d;
    logic                  abort_q, abort_d;
    logic                  sof_q, sof_d;
    logic                  nb_q, nb_d;
    logic                  ovf_q, ovf_d;
    logic                  stb_q, stb_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;

    logic                  start, px_ok, wr_en, wr_full, rd_ready, free, flush;
    logic [WordIdxBits-1:0] rd_word;
    logic [63:0]           rd_data;

    // Pixel acceptance: SOF pixel opens a capture, plain pixels only while capturing.
    always_comb begin
        start = v_stb & v_sof & ~in_frame_q & field_filter[v_field];
        px_ok = v_stb & ~v_sof & in_frame_q & ~abort_q;
        wr_en = start | (px_ok & ~wr_full);
    end

    // Word index presented on fml_do for each FSM state.
    always_comb begin
        case (state_q)
            StD1:    rd_word = 2'd1;
            StD2:    rd_word = 2'd2;
            StD3:    rd_word = 2'd3;
            default: rd_word = 2'd0;
        endcase
    end

    // Write FSM, burst pointer and frame/abort tracking next-state.
    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q | start;
        abort_d    = abort_q | (v_stb & v_sof & in_frame_q);
        ptr_d      = start ? fml_adr_base : ptr_q;
        free       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            StIdle: begin
                if (abort_q) begin
                    flush      = 1'b1;
                    in_frame_d = 1'b0;
                    abort_d    = 1'b0;
                end else if (in_frame_q && rd_ready) begin
                    state_d = StReq;
                end
            end
            StReq: if (fml.fml_ack) state_d = StD1;
            StD1:  state_d = StD2;
            StD2:  state_d = StD3;
            StD3: begin
                free    = 1'b1;
                ptr_d   = ptr_q + PtrW'(1);
                state_d = StChk;
            end
            StChk: begin
                if (last_burst || abort_q) begin
                    flush      = 1'b1;
                    in_frame_d = 1'b0;
                    abort_d    = 1'b0;
                    state_d    = StIdle;
                end else if (rd_ready) begin
                    state_d = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        sof_d = start;
        nb_d  = (state_d == StD3);
        ovf_d = px_ok & wr_full;
        stb_d = (state_d == StReq);
    end

    // All control state and registered outputs; reset drops fml_stb immediately.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            in_frame_q <= 1'b0;
            abort_q    <= 1'b0;
            sof_q      <= 1'b0;
            nb_q       <= 1'b0;
            ovf_q      <= 1'b0;
            stb_q      <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            abort_q    <= abort_d;
            sof_q      <= sof_d;
            nb_q       <= nb_d;
            ovf_q      <= ovf_d;
            stb_q      <= stb_d;
            ptr_q      <= ptr_d;
        end
    end

    bt656cap_burstbuf u_burstbuf (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .flush_i    (flush),
        .wr_en_i    (wr_en),
        .wr_data_i  (v_rgb565),
        .free_i     (free),
        .rd_word_i  (rd_word),
        .wr_full_o  (wr_full),
        .rd_ready_o (rd_ready),
        .rd_data_o  (rd_data)
    );

    assign in_frame       = in_frame_q;
    assign start_of_frame = sof_q;
    assign next_burst     = nb_q;
    assign overflow       = ovf_q;

    assign fml.fml_adr = {ptr_q, {BurstAdrBits{1'b0}}};
    assign fml.fml_stb = stb_q;
    assign fml.fml_we  = 1'b1;
    assign fml.fml_sel = 8'hff;
    assign fml.fml_do  = rd_data;

endmodule

// File: tb/tb_bt656cap_dma.sv
// Directed bench for bt656cap_dma with an FML slave, a ctlif last_burst model and a write monitor.
module tb_bt656cap_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_stb, v_sof, v_field;
    logic [15:0] v_rgb565;
    logic [1:0]  field_filter;
    logic [21:0] fml_adr_base;
    logic        last_burst;
    logic        in_frame, start_of_frame, next_burst, overflow;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 0;
    int ack_wait = 0;
    int max_bursts = 1000;
    int nb_cnt = 0;
    int beat = 0;
    int stb_seen = 0;
    int ovf_seen = 0;
    logic [63:0] words[$];
    logic [26:0] adrs[$];

    bt656cap_dma_if #(.fml_depth(27)) fml_bus ();

    bt656cap_dma #(.fml_depth(27)) dut (
        .sys_clk        (clk),
        .sys_rst_n      (rst_n),
        .v_stb          (v_stb),
        .v_sof          (v_sof),
        .v_field        (v_field),
        .v_rgb565       (v_rgb565),
        .field_filter   (field_filter),
        .fml_adr_base   (fml_adr_base),
        .last_burst     (last_burst),
        .in_frame       (in_frame),
        .start_of_frame (start_of_frame),
        .next_burst     (next_burst),
        .overflow       (overflow),
        .fml            (fml_bus)
    );

    always #5 clk = ~clk;

    // FML slave: ack after ack_delay stalled cycles of fml_stb.
    assign fml_bus.fml_ack = fml_bus.fml_stb && (ack_wait == ack_delay);
    always @(posedge clk) begin
        if (fml_bus.fml_stb && !fml_bus.fml_ack) ack_wait <= ack_wait + 1;
        else ack_wait <= 0;
    end

    // ctlif model: last_burst one cycle after the max_bursts-th next_burst.
    always @(posedge clk) begin
        if (!rst_n) begin
            nb_cnt     <= 0;
            last_burst <= 1'b0;
        end else begin
            last_burst <= next_burst && (nb_cnt + 1 == max_bursts);
            if (next_burst) nb_cnt <= nb_cnt + 1;
        end
    end

    // Write monitor: address at the ack beat, then four data words.
    always @(negedge clk) begin
        if (!rst_n) begin
            beat     <= 0;
            stb_seen <= 0;
            ovf_seen <= 0;
            words.delete();
            adrs.delete();
        end else begin
            if (fml_bus.fml_stb) stb_seen <= stb_seen + 1;
            if (overflow) ovf_seen <= ovf_seen + 1;
            if (beat != 0) begin
                words.push_back(fml_bus.fml_do);
                beat <= beat - 1;
            end else if (fml_bus.fml_stb && fml_bus.fml_ack) begin
                adrs.push_back(fml_bus.fml_adr);
                words.push_back(fml_bus.fml_do);
                beat <= 3;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [15:0] d, input logic sof, input logic fld);
        v_stb    = 1'b1;
        v_sof    = sof;
        v_field  = fld;
        v_rgb565 = d;
        tick();
        v_stb = 1'b0;
        v_sof = 1'b0;
    endtask

    task automatic send_run(input logic [15:0] first, input int n, input logic fld);
        for (int i = 0; i < n; i++) send_px(first + 16'(i), 1'b0, fld);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v_stb = 1'b0;
        v_sof = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        v_stb        = 1'b0;
        v_sof        = 1'b0;
        v_field      = 1'b0;
        v_rgb565     = 16'h0;
        field_filter = 2'b00;
        fml_adr_base = 22'h1000;
        tick();
        tick();
        check("rst_in_frame", in_frame, 0);
        check("rst_sof", start_of_frame, 0);
        check("rst_next_burst", next_burst, 0);
        check("rst_overflow", overflow, 0);
        check("rst_stb", fml_bus.fml_stb, 0);
        check("rst_adr", fml_bus.fml_adr, 0);
        check("rst_we", fml_bus.fml_we, 1);
        check("rst_sel", fml_bus.fml_sel, 8'hff);
        rst_n = 1'b1;

        // 1: even field, one burst at base 0x1000 -> byte address 0x20000.
        field_filter = 2'b01;
        send_px(16'hA000, 1'b1, 1'b0);
        check("t1_sof_pulse", start_of_frame, 1);
        check("t1_in_frame", in_frame, 1);
        send_px(16'hA001, 1'b0, 1'b0);
        check("t1_sof_one_cycle", start_of_frame, 0);
        send_run(16'hA002, 14, 1'b0);
        repeat (8) tick();
        check("t1_n_writes", adrs.size(), 1);
        check("t1_adr", adrs[0], 27'h20000);
        check("t1_w0", words[0], 64'hA000_A001_A002_A003);
        check("t1_w1", words[1], 64'hA004_A005_A006_A007);
        check("t1_w2", words[2], 64'hA008_A009_A00A_A00B);
        check("t1_w3", words[3], 64'hA00C_A00D_A00E_A00F);
        check("t1_nb_count", nb_cnt, 1);

        // 2: stalled ack, second buffer fills, next pixel overflows.
        do_reset();
        ack_delay = 20;
        send_px(16'hA000, 1'b1, 1'b0);
        send_run(16'hA001, 15, 1'b0);
        send_px(16'hA010, 1'b0, 1'b0);
        check("t2_stb_held", fml_bus.fml_stb, 1);
        check("t2_adr_held", fml_bus.fml_adr, 27'h20000);
        send_run(16'hA011, 15, 1'b0);
        send_px(16'hA020, 1'b0, 1'b0);
        check("t2_overflow", overflow, 1);
        check("t2_stb_still", fml_bus.fml_stb, 1);
        check("t2_adr_still", fml_bus.fml_adr, 27'h20000);
        tick();
        check("t2_overflow_pulse", overflow, 0);
        repeat (80) tick();
        check("t2_n_writes", adrs.size(), 2);
        check("t2_adr1", adrs[1], 27'h20020);
        check("t2_b0_w3", words[3], 64'hA00C_A00D_A00E_A00F);
        check("t2_b1_w0", words[4], 64'hA010_A011_A012_A013);
        check("t2_b1_w3", words[7], 64'hA01C_A01D_A01E_A01F);
        check("t2_ovf_count", ovf_seen, 1);

        // 3: ctlif ends the frame after three bursts.
        do_reset();
        ack_delay  = 0;
        max_bursts = 3;
        send_px(16'hA000, 1'b1, 1'b0);
        send_run(16'hA001, 63, 1'b0);
        repeat (10) tick();
        check("t3_in_frame_low", in_frame, 0);
        send_run(16'hA040, 16, 1'b0);
        repeat (10) tick();
        check("t3_nb_count", nb_cnt, 3);
        check("t3_n_writes", adrs.size(), 3);
        check("t3_adr0", adrs[0], 27'h20000);
        check("t3_adr1", adrs[1], 27'h20020);
        check("t3_adr2", adrs[2], 27'h20040);
        check("t3_b2_w0", words[8], 64'hA020_A021_A022_A023);
        check("t3_in_frame_end", in_frame, 0);
        max_bursts = 1000;

        // 4: odd-only filter, filter change mid-frame, then capture disabled.
        do_reset();
        field_filter = 2'b10;
        send_px(16'hC000, 1'b1, 1'b0);
        check("t4_even_no_sof", start_of_frame, 0);
        check("t4_even_no_frame", in_frame, 0);
        send_run(16'hC001, 15, 1'b0);
        send_px(16'hD000, 1'b1, 1'b1);
        check("t4_odd_sof", start_of_frame, 1);
        field_filter = 2'b00;
        send_run(16'hD001, 15, 1'b1);
        repeat (8) tick();
        check("t4_n_writes", adrs.size(), 1);
        check("t4_w0", words[0], 64'hD000_D001_D002_D003);
        do_reset();
        field_filter = 2'b00;
        send_px(16'hE000, 1'b1, 1'b0);
        check("t4_off_no_sof", start_of_frame, 0);
        send_run(16'hE001, 31, 1'b0);
        send_px(16'hE100, 1'b1, 1'b1);
        send_run(16'hE101, 31, 1'b1);
        repeat (10) tick();
        check("t4_off_no_stb", stb_seen, 0);
        check("t4_off_in_frame", in_frame, 0);

        // 5: SOF arrives while the first burst is in D2, 8 px into the second buffer.
        do_reset();
        field_filter = 2'b01;
        ack_delay    = 5;
        send_px(16'hA000, 1'b1, 1'b0);
        send_run(16'hA001, 15, 1'b0);
        send_run(16'hA010, 8, 1'b0);
        check("t5_d2_no_stb", fml_bus.fml_stb, 0);
        check("t5_d2_no_nb", nb_cnt, 0);
        send_px(16'hF000, 1'b1, 1'b0);
        check("t5_abort_no_sof", start_of_frame, 0);
        check("t5_burst_completes", next_burst, 1);
        send_run(16'hF001, 4, 1'b0);
        repeat (10) tick();
        check("t5_in_frame_low", in_frame, 0);
        check("t5_nb_count", nb_cnt, 1);
        check("t5_n_words", words.size(), 4);
        send_px(16'hB000, 1'b1, 1'b0);
        check("t5_restart_sof", start_of_frame, 1);
        send_run(16'hB001, 15, 1'b0);
        repeat (15) tick();
        check("t5_n_writes", adrs.size(), 2);
        check("t5_restart_adr", adrs[1], 27'h20000);
        check("t5_restart_w0", words[4], 64'hB000_B001_B002_B003);
        check("t5_restart_w3", words[7], 64'hB00C_B00D_B00E_B00F);

        // 6: reset during D1, then reset while fml_stb is stalled high.
        do_reset();
        ack_delay = 0;
        send_px(16'hA000, 1'b1, 1'b0);
        send_run(16'hA001, 15, 1'b0);
        tick();
        check("t6_req_stb", fml_bus.fml_stb, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("t6_rst_stb", fml_bus.fml_stb, 0);
        check("t6_rst_in_frame", in_frame, 0);
        check("t6_rst_adr", fml_bus.fml_adr, 0);
        check("t6_rst_nb", next_burst, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_sof", start_of_frame, 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("t6_quiet_after", stb_seen, 0);
        check("t6_in_frame_after", in_frame, 0);
        do_reset();
        ack_delay = 10;
        send_px(16'hA000, 1'b1, 1'b0);
        send_run(16'hA001, 15, 1'b0);
        tick();
        check("t6b_stalled_stb", fml_bus.fml_stb, 1);
        rst_n = 1'b0;
        tick();
        check("t6b_rst_stb", fml_bus.fml_stb, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
